// File: rtl/hit_input_if.sv
// hit_input_if: raw button inputs and conditioned hit/start strobes between the buttons and the game controller.
interface hit_input_if;
  logic [15:0] btn_raw;
  logic        start_raw;
  logic        hit;
  logic [3:0]  hit_index;
  logic        game_start;
  logic [15:0] btn_level;
  modport master(output btn_raw, start_raw, input hit, hit_index, game_start, btn_level);
  modport slave(input btn_raw, start_raw, output hit, hit_index, game_start, btn_level);
endinterface

// File: rtl/hit_input.sv
// hit_input: synchronise and debounce 16 hole buttons plus start; queue presses and issue one hit per clock, lowest index first.
module hit_input #(
  parameter int TICK_DIV = 250000,
  parameter int SAMPLES  = 3
) (
  input logic       clk,
  input logic       rst,
  hit_input_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  logic [16:0]        r_s1, r_s2, r_lvl, w_lvl, w_rise;
  logic [SAMPLES-1:0] r_hist [17];
  logic [SAMPLES-1:0] w_hist [17];
  logic [CW-1:0]      r_cnt;
  logic [15:0]        r_pend, w_grant;
  logic [3:0]         r_idx, w_idx;
  logic               r_sp, r_gs, r_hit, w_tick;
  assign w_tick = r_cnt == CW'(TICK_DIV - 1);
  // channel 16 is the start button; it shares the debounce path but bypasses the arbiter
  for (genvar i = 0; i < 17; i++) begin : g_ch
    assign w_hist[i] = {r_hist[i][SAMPLES-2:0], r_s2[i]};
    assign w_lvl[i]  = &w_hist[i] ? 1'b1 : (~|w_hist[i] ? 1'b0 : r_lvl[i]);
  end
  assign w_rise  = w_tick ? (w_lvl & ~r_lvl) : '0;
  assign w_grant = r_pend & (~r_pend + 16'd1);
  always_comb begin
    w_idx = '0;
    for (int i = 15; i >= 0; i--) if (r_pend[i]) w_idx = 4'(i);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cnt  <= '0;
      r_lvl  <= '0;
      r_pend <= '0;
      r_sp   <= 1'b0;
      r_gs   <= 1'b0;
      r_hit  <= 1'b0;
      r_idx  <= '0;
      for (int i = 0; i < 17; i++) r_hist[i] <= '0;
    end else begin
      r_s1  <= {bus.start_raw, bus.btn_raw};
      r_s2  <= r_s1;
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_hist <= w_hist;
        r_lvl  <= w_lvl;
      end
      // a new press on the bit being granted re-sets it, so it stays pending
      r_pend <= (r_pend & ~w_grant) | w_rise[15:0];
      r_sp   <= w_rise[16];
      r_gs   <= r_sp;
      r_hit  <= |r_pend;
      r_idx  <= w_idx;
    end
  assign bus.hit        = r_hit;
  assign bus.hit_index  = r_idx;
  assign bus.game_start = r_gs;
  assign bus.btn_level  = r_lvl[15:0];
endmodule

// File: tb/tb_hit_input.sv
// tb_hit_input: directed scenarios against a run-length debounce model with per-cycle output comparison.
module tb_hit_input;
  localparam int TD = 4, S = 3;
  logic clk = 1'b0, rst = 1'b1;
  hit_input_if bus();
  hit_input #(.TICK_DIV(TD), .SAMPLES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  int q_idx[$], q_hc[$], q_gc[$];
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // model: each input's samples tracked as (current run value, run length); level follows a run of S
  logic [16:0] m_d1, m_d2, m_lvl, m_rise;
  logic [15:0] m_pend;
  logic        m_sp, m_gs, m_hit;
  logic [3:0]  m_idx;
  int          m_n, m_rv[17], m_rl[17];
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pend = '0;
      m_sp = 1'b0; m_gs = 1'b0; m_hit = 1'b0; m_idx = '0; m_n = 0;
      for (int i = 0; i < 17; i++) begin m_rv[i] = 0; m_rl[i] = S; end
    end else begin
      m_hit = m_pend != 0;
      m_idx = '0;
      for (int i = 15; i >= 0; i--) if (m_pend[i]) m_idx = 4'(i);
      if (m_hit) m_pend[m_idx] = 1'b0;
      m_gs = m_sp;
      m_rise = '0;
      if (m_n % TD == TD - 1)
        for (int i = 0; i < 17; i++) begin
          if (int'(m_d2[i]) == m_rv[i]) m_rl[i] = (m_rl[i] < S) ? m_rl[i] + 1 : S;
          else begin m_rv[i] = int'(m_d2[i]); m_rl[i] = 1; end
          if (m_rl[i] >= S && m_rv[i] != int'(m_lvl[i])) begin
            m_rise[i] = m_rv[i] == 1;
            m_lvl[i]  = m_rv[i] == 1;
          end
        end
      m_pend = m_pend | m_rise[15:0];
      m_sp   = m_rise[16];
      m_d2   = m_d1;
      m_d1   = {bus.start_raw, bus.btn_raw};
      m_n++;
    end
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    chk("hit", int'(bus.hit), int'(m_hit));
    chk("hit_index", int'(bus.hit_index), int'(m_idx));
    chk("game_start", int'(bus.game_start), int'(m_gs));
    chk("btn_level", int'(bus.btn_level), int'(m_lvl[15:0]));
    if (bus.hit) begin q_idx.push_back(int'(bus.hit_index)); q_hc.push_back(cyc); end
    if (bus.game_start) q_gc.push_back(cyc);
  end
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int b, g, t0;
    bus.btn_raw = '0;
    bus.start_raw = 1'b0;
    #1 rst = 1'b0;
    cycles(3);
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_idx", int'(bus.hit_index), 0);
    chk("rst_gs", int'(bus.game_start), 0);
    chk("rst_level", int'(bus.btn_level), 0);
    #2 rst = 1'b1;
    cycles(10);
    // single press and release
    b = q_idx.size(); t0 = cyc;
    bus.btn_raw[5] = 1'b1;
    cycles(40);
    chk("s1_count", q_idx.size() - b, 1);
    if (q_idx.size() > b) begin
      chk("s1_idx", q_idx[b], 5);
      chk("s1_latency_max", int'(q_hc[b] - t0 <= 15), 1);
      chk("s1_latency_min", int'(q_hc[b] - t0 >= 11), 1);
    end
    chk("s1_level", int'(bus.btn_level[5]), 1);
    bus.btn_raw[5] = 1'b0;
    cycles(30);
    chk("s1_release", q_idx.size() - b, 1);
    chk("s1_level_off", int'(bus.btn_level), 0);
    // bounce then hold
    b = q_idx.size();
    for (int k = 0; k < 30; k++) begin bus.btn_raw[2] = ~bus.btn_raw[2]; cycles(1); end
    bus.btn_raw[2] = 1'b1;
    cycles(30);
    chk("s2_bounce_count", q_idx.size() - b, 1);
    if (q_idx.size() > b) chk("s2_bounce_idx", q_idx[b], 2);
    bus.btn_raw[2] = 1'b0;
    cycles(30);
    // short glitch
    b = q_idx.size();
    bus.btn_raw[9] = 1'b1;
    cycles(5);
    bus.btn_raw[9] = 1'b0;
    cycles(30);
    chk("s2_glitch_count", q_idx.size() - b, 0);
    // simultaneous presses
    b = q_idx.size();
    bus.btn_raw[12] = 1'b1; bus.btn_raw[3] = 1'b1; bus.btn_raw[7] = 1'b1;
    cycles(30);
    chk("s3_count", q_idx.size() - b, 3);
    if (q_idx.size() - b == 3) begin
      chk("s3_idx0", q_idx[b], 3);
      chk("s3_idx1", q_idx[b+1], 7);
      chk("s3_idx2", q_idx[b+2], 12);
      chk("s3_gap1", q_hc[b+1] - q_hc[b], 1);
      chk("s3_gap2", q_hc[b+2] - q_hc[b], 2);
    end
    bus.btn_raw = '0;
    cycles(30);
    // start coincident with hit
    b = q_idx.size(); g = q_gc.size();
    bus.start_raw = 1'b1; bus.btn_raw[0] = 1'b1;
    cycles(30);
    chk("s4_hit_count", q_idx.size() - b, 1);
    chk("s4_gs_count", q_gc.size() - g, 1);
    if (q_idx.size() > b && q_gc.size() > g) begin
      chk("s4_idx", q_idx[b], 0);
      chk("s4_same_cycle", q_gc[g] - q_hc[b], 0);
    end
    bus.start_raw = 1'b0; bus.btn_raw = '0;
    cycles(30);
    // full drain with a brief re-press of 15
    b = q_idx.size();
    bus.btn_raw = 16'hFFFF;
    for (int k = 0; k < 40 && q_idx.size() == b; k++) cycles(1);
    chk("s5_started", int'(q_idx.size() > b), 1);
    bus.btn_raw[15] = 1'b0;
    cycles(2);
    bus.btn_raw[15] = 1'b1;
    cycles(30);
    chk("s5_count", q_idx.size() - b, 16);
    if (q_idx.size() - b == 16)
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("s5_idx%0d", i), q_idx[b+i], i);
        chk($sformatf("s5_cyc%0d", i), q_hc[b+i] - q_hc[b], i);
      end
    bus.btn_raw = '0;
    cycles(30);
    // reset with presses pending
    bus.btn_raw[1] = 1'b1; bus.btn_raw[4] = 1'b1; bus.btn_raw[6] = 1'b1; bus.btn_raw[8] = 1'b1;
    for (int k = 0; k < 40 && !bus.hit; k++) cycles(1);
    chk("s6_hit_before", int'(bus.hit), 1);
    #2 rst = 1'b0;
    #1;
    chk("s6_rst_hit", int'(bus.hit), 0);
    chk("s6_rst_idx", int'(bus.hit_index), 0);
    chk("s6_rst_gs", int'(bus.game_start), 0);
    chk("s6_rst_level", int'(bus.btn_level), 0);
    bus.btn_raw = '0;
    cycles(3);
    b = q_idx.size();
    #2 rst = 1'b1;
    cycles(40);
    chk("s6_no_stale", q_idx.size() - b, 0);
    // start held through reset
    cycles(1);
    #2 begin bus.start_raw = 1'b1; rst = 1'b0; end
    cycles(3);
    g = q_gc.size();
    #2 rst = 1'b1;
    cycles(40);
    chk("s6_start_through_reset", q_gc.size() - g, 1);
    bus.start_raw = 1'b0;
    cycles(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
endmodule
